bank_conflict_scheduler: RTL and testbench
==========================================

# bank_conflict_scheduler

Sequences one multi-lane memory request across a banked memory and splits it into conflict-free passes. Each lane address is mapped to a bank and a row using the team's XOR-swizzled interleave. Per pass, the block issues at most one lane per bank, so lanes that collide on a bank are serialized. It sits between the SM load/store unit and the banked shared-memory/L1 array, and reports the pass count so the issuing warp can be charged the conflict penalty.

## Interface
- ADDR_WIDTH, 32, address width per lane
- BANKS, 8, number of banks; power of two, ≥2; B = $clog2(BANKS)
- LANES, 4, lanes per request, ≥1; L = max(1,$clog2(LANES))
- SWIZZLE, 1, 1 = bank is addr[B-1:0] ^ addr[2B-1:B]; 0 = bank is addr[B-1:0]
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  scheduler can accept
- req_mask  in  LANES  active lanes
- req_addr  in  LANES*ADDR_WIDTH  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- issue_valid  out  BANKS  bank b accessed this pass
- issue_row  out  BANKS*(ADDR_WIDTH-B)  row for bank b (addr >> B)
- issue_lane  out  BANKS*L  lane index served by bank b
- mem_ready  in  1  memory accepts the current pass
- done  out  1  one-cycle pulse: request fully issued
- pass_count  out  $clog2(LANES+1)  passes used; valid while done=1

## Operation
- Bank/row per lane: row = addr >> B (width ADDR_WIDTH-B); bank as selected by SWIZZLE. Identical addresses are not merged; they conflict like any other same-bank pair.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the addresses. Build pass 1 from req_mask: for each bank, pick the lowest-indexed active lane mapping to it. Load the pass into the issue_* registers and set pending = req_mask minus the lanes issued.
  - mask≠0: go to ISSUE with pass_count=1.
  - mask=0: go to DONE with pass_count=0 and issue_valid=0.
- ISSUE: issue_* are held stable while mem_ready=0. When mem_ready=1:
  - pending=0: issue_valid is cleared and the FSM goes to DONE.
  - pending≠0: the next pass is loaded (same lowest-lane-per-bank rule on pending), those lanes are cleared from pending, and pass_count increments.
- DONE: done=1 for exactly one cycle, req_ready=0, then IDLE.
- issue_row/issue_lane of banks with issue_valid=0 are don't-care; they are driven to 0.
- pass_count equals the maximum number of active lanes mapped to any single bank.
- Reset, including mid-request: FSM to IDLE; pending, pass_count, issue_valid, issue_row, issue_lane and done to 0. After reset deassertion req_ready=1.

## Timing
- req_ready=1 only in IDLE. No new request is accepted until the DONE cycle has passed.
- Acceptance happens on edge 0. Pass 1 is visible from cycle 1 (registered outputs, no combinational path from req_* to issue_*).
- With mem_ready held high and P≥1 passes:
  - passes occupy cycles 1..P;
  - done with pass_count=P in cycle P+1;
  - req_ready=1 again in cycle P+2.
- Empty mask: done with pass_count=0 in cycle 1; req_ready in cycle 2.
- Each low cycle of mem_ready during ISSUE adds one cycle of latency. A pass is consumed only on a cycle where issue_valid≠0 and mem_ready=1.
- mem_ready is ignored outside ISSUE.

## Test plan
- Default parameters, mask=4'hF, addrs 0x00,0x01,0x02,0x03 -> one pass. Cycle 1: issue_valid=8'h0F, lanes 0..3 on banks 0..3, rows all 0. done with pass_count=1 in cycle 2.
- SWIZZLE=1, mask=F, addrs 0x00,0x09,0x12,0x1B (all bank 0) -> four passes, each issue_valid=8'h01. Lanes 0,1,2,3 in order, rows 0,1,2,3. done with pass_count=4 in cycle 5.
- Addrs 0x00,0x08,0x10,0x18:
  - SWIZZLE=1 -> banks 0,1,2,3, one pass, issue_valid=8'h0F.
  - SWIZZLE=0 -> four passes on bank 0, pass_count=4.
- Conflict case from the second scenario with mem_ready low for cycles 1–2 -> pass 1 (lane 0) held unchanged through cycle 3. done in cycle 7. req_valid held high throughout is not accepted until req_ready returns.
- mask=4'b0000 -> issue_valid stays 0, done with pass_count=0 in cycle 1. mask=4'b1010 with lanes 1,3 both bank 5 -> lane 1 then lane 3, pass_count=2.
- rst_n asserted asynchronously mid-way through pass 2 of the 4-pass case -> all outputs 0 immediately, req_ready=1 after release. A new request then completes normally, with no stale lanes issued.

Source files
------------

// File: rtl/bank_conflict_scheduler.sv
// Banked-memory request scheduler: splits one multi-lane request into
// conflict-free passes (at most one lane per bank per pass).

// Per-lane address decode: bank select (optionally XOR-swizzled) and row.
module bcs_lane_map #(
  parameter int ADDR_WIDTH = 32,
  parameter int B          = 3,
  parameter int SWIZZLE    = 1
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic [B-1:0]            bank,
  output logic [ADDR_WIDTH-B-1:0] row
);
  assign row = addr[ADDR_WIDTH-1:B];
  if (SWIZZLE != 0) begin : g_swz
    assign bank = addr[B-1:0] ^ addr[2*B-1:B];
  end else begin : g_lin
    assign bank = addr[B-1:0];
  end
endmodule

module bank_conflict_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int BANKS      = 8,
  parameter int LANES      = 4,
  parameter int SWIZZLE    = 1,
  localparam int B   = $clog2(BANKS),
  localparam int L   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int RW  = ADDR_WIDTH - B,
  localparam int PCW = $clog2(LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [LANES-1:0]            req_mask,
  input  logic [LANES*ADDR_WIDTH-1:0] req_addr,
  output logic [BANKS-1:0]            issue_valid,
  output logic [BANKS*RW-1:0]         issue_row,
  output logic [BANKS*L-1:0]          issue_lane,
  input  logic                        mem_ready,
  output logic                        done,
  output logic [PCW-1:0]              pass_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state_q, state_d;

  logic [LANES-1:0][ADDR_WIDTH-1:0] addr_q, src_addr;
  logic [LANES-1:0]                 src_mask, pend_q, take;
  logic [LANES-1:0][B-1:0]          lbank;
  logic [LANES-1:0][RW-1:0]         lrow;
  logic [BANKS-1:0]                 nv, iv_q;
  logic [BANKS-1:0][RW-1:0]         nrow, irow_q;
  logic [BANKS-1:0][L-1:0]          nlane, ilane_q;
  logic [PCW-1:0]                   pc_q;
  logic                             accept, load, clear;

  // The pass builder sees the live request in IDLE, the latched one afterwards.
  assign accept   = (state_q == IDLE) && req_valid;
  assign src_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign src_mask = (state_q == IDLE) ? req_mask : pend_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bcs_lane_map #(.ADDR_WIDTH(ADDR_WIDTH), .B(B), .SWIZZLE(SWIZZLE)) u_map (
      .addr (src_addr[i]),
      .bank (lbank[i]),
      .row  (lrow[i])
    );
  end

  // A lane wins its bank when no lower-indexed candidate lane maps there.
  always_comb begin
    take = '0;
    for (int l = 0; l < LANES; l++) begin
      take[l] = src_mask[l];
      for (int j = 0; j < l; j++)
        if (src_mask[j] && (lbank[j] == lbank[l])) take[l] = 1'b0;
    end
  end

  // Scatter the winning lanes onto their banks; idle banks read as zero.
  always_comb begin
    nv    = '0;
    nrow  = '0;
    nlane = '0;
    for (int b = 0; b < BANKS; b++)
      for (int l = 0; l < LANES; l++)
        if (take[l] && (lbank[l] == B'(b))) begin
          nv[b]    = 1'b1;
          nrow[b]  = lrow[l];
          nlane[b] = L'(l);
        end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and pass load/clear strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        load    = 1'b1;
        state_d = (req_mask != '0) ? ISSUE : DONE;
      end
      ISSUE: if (mem_ready) begin
        if (pend_q == '0) begin
          clear   = 1'b1;
          state_d = DONE;
        end else begin
          load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, pending mask, pass counter and registered issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      pend_q  <= '0;
      pc_q    <= '0;
      iv_q    <= '0;
      irow_q  <= '0;
      ilane_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        pc_q   <= (req_mask != '0) ? PCW'(1) : '0;
      end else if (load) begin
        pc_q <= pc_q + PCW'(1);
      end
      if (load) begin
        iv_q    <= nv;
        irow_q  <= nrow;
        ilane_q <= nlane;
        pend_q  <= src_mask & ~take;
      end else if (clear) begin
        iv_q    <= '0;
        irow_q  <= '0;
        ilane_q <= '0;
      end
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign pass_count  = pc_q;
  assign issue_valid = iv_q;
  assign issue_row   = irow_q;
  assign issue_lane  = ilane_q;
endmodule

// File: tb/tb_bank_conflict_scheduler.sv
// Bench: table of requests checked pass-by-pass against a scoreboard of
// expected passes, plus a hand-written asynchronous reset sequence.
module tb_bank_conflict_scheduler;
  localparam int AW = 32, NB = 8, NL = 4, RW = 29, LW = 2, PCW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                req_valid = 1'b0, req_valid0 = 1'b0, mem_ready = 1'b1;
  logic [NL-1:0]       req_mask = '0;
  logic [NL*AW-1:0]    req_addr = '0;
  logic                rr1, dn1, rr0, dn0;
  logic [NB-1:0]       iv1, iv0;
  logic [NB*RW-1:0]    ir1, ir0;
  logic [NB*LW-1:0]    il1, il0;
  logic [PCW-1:0]      pc1, pc0;

  bank_conflict_scheduler #(.ADDR_WIDTH(AW), .BANKS(NB), .LANES(NL), .SWIZZLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1),
    .req_mask(req_mask), .req_addr(req_addr), .issue_valid(iv1), .issue_row(ir1),
    .issue_lane(il1), .mem_ready(mem_ready), .done(dn1), .pass_count(pc1));

  bank_conflict_scheduler #(.ADDR_WIDTH(AW), .BANKS(NB), .LANES(NL), .SWIZZLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(rr0),
    .req_mask(req_mask), .req_addr(req_addr), .issue_valid(iv0), .issue_row(ir0),
    .issue_lane(il0), .mem_ready(mem_ready), .done(dn0), .pass_count(pc0));

  typedef struct {
    logic [NB-1:0]    v;
    logic [NB*RW-1:0] row;
    logic [NB*LW-1:0] lane;
  } pass_t;

  typedef struct {
    bit             swz;
    logic [3:0]     mask;
    logic [3:0][31:0] addr;
    logic [7:0]     lowmask;   // bit k: mem_ready low in cycle k
    bit             hold;      // keep req_valid high for the whole run
    int             exp_pc;
    logic [7:0]     exp_v1;
    int             exp_done;
  } vec_t;

  pass_t sbq[$];
  vec_t  tbl[8];
  int    checks = 0, failures = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int mbank(input logic [31:0] a, input bit swz);
    return swz ? int'(a[2:0] ^ a[5:3]) : int'(a[2:0]);
  endfunction

  // Expected passes: each pass takes the lowest pending lane per bank.
  task automatic push_passes(input logic [3:0] mask, input logic [3:0][31:0] a, input bit swz);
    logic [3:0] pend;
    pass_t p;
    int bk;
    pend = mask;
    while (pend != 0) begin
      p.v = '0; p.row = '0; p.lane = '0;
      for (int l = 0; l < NL; l++) begin
        bk = mbank(a[l], swz);
        if (pend[l] && !p.v[bk]) begin
          p.v[bk] = 1'b1;
          p.row[bk*RW +: RW] = a[l][31:3];
          p.lane[bk*LW +: LW] = LW'(l);
          pend[l] = 1'b0;
        end
      end
      sbq.push_back(p);
    end
  endtask

  function automatic bit lowc(input vec_t t, input int c);
    return (c < 8) ? t.lowmask[c] : 1'b0;
  endfunction

  task automatic run(input vec_t t);
    int cyc;
    bit seen_done, first;
    pass_t p;
    logic [NB-1:0] v;
    logic [NB*RW-1:0] r;
    logic [NB*LW-1:0] ln;
    seen_done = 0; first = 1;
    sbq.delete();
    push_passes(t.mask, t.addr, t.swz);
    @(negedge clk);
    chk("ready_before_req", t.swz ? rr1 : rr0, 1);
    req_mask = t.mask; req_addr = t.addr; mem_ready = 1'b1;
    if (t.swz) req_valid = 1'b1; else req_valid0 = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!t.hold) begin req_valid = 1'b0; req_valid0 = 1'b0; end
      v  = t.swz ? iv1 : iv0;
      r  = t.swz ? ir1 : ir0;
      ln = t.swz ? il1 : il0;
      chk("busy_not_ready", t.swz ? rr1 : rr0, 0);
      if (t.swz ? dn1 : dn0) begin
        seen_done = 1;
        chk("done_cycle", cyc, t.exp_done);
        chk("pass_count", t.swz ? pc1 : pc0, t.exp_pc);
        chk("passes_left", sbq.size(), 0);
        chk("done_issue_valid", v, 0);
      end else if (v != '0) begin
        if (sbq.size() == 0) chk("extra_pass", v, 0);
        else begin
          p = sbq[0];
          if (first) chk("first_issue_valid", v, t.exp_v1);
          first = 0;
          chk("issue_valid", v, p.v);
          chk("issue_row", r, p.row);
          chk("issue_lane", ln, p.lane);
          if (!lowc(t, cyc)) void'(sbq.pop_front());
        end
      end
      mem_ready = !lowc(t, cyc);
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0; req_valid0 = 1'b0; mem_ready = 1'b1;
    chk("ready_after_done", t.swz ? rr1 : rr0, 1);
  endtask

  initial begin
    tbl[0] = '{1, 4'hF, {32'h03, 32'h02, 32'h01, 32'h00}, 8'h00, 0, 1, 8'h0F, 2};
    tbl[1] = '{1, 4'hF, {32'h1B, 32'h12, 32'h09, 32'h00}, 8'h00, 0, 4, 8'h01, 5};
    tbl[2] = '{1, 4'hF, {32'h18, 32'h10, 32'h08, 32'h00}, 8'h00, 0, 1, 8'h0F, 2};
    tbl[3] = '{0, 4'hF, {32'h18, 32'h10, 32'h08, 32'h00}, 8'h00, 0, 4, 8'h01, 5};
    tbl[4] = '{1, 4'hF, {32'h1B, 32'h12, 32'h09, 32'h00}, 8'h06, 1, 4, 8'h01, 7};
    tbl[5] = '{1, 4'h0, {32'h1B, 32'h12, 32'h09, 32'h00}, 8'h00, 0, 0, 8'h00, 1};
    tbl[6] = '{1, 4'hA, {32'h28, 32'h05, 32'h28, 32'h05}, 8'h00, 0, 2, 8'h20, 3};
    tbl[7] = '{1, 4'hF, {32'h41, 32'h01, 32'h40, 32'h00}, 8'h00, 0, 2, 8'h03, 3};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", rr1, 1);
    chk("reset_done", dn1, 0);
    chk("reset_issue_valid", iv1, 0);
    chk("reset_pass_count", pc1, 0);

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // Asynchronous reset in the middle of pass 2 of the all-bank-0 case.
    @(negedge clk);
    req_mask = 4'hF; req_addr = {32'h1B, 32'h12, 32'h09, 32'h00}; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_seq_pass1_lane", il1[1:0], 0);
    @(posedge clk);
    #2;
    chk("rst_seq_pass2_valid", iv1, 8'h01);
    chk("rst_seq_pass2_lane", il1[1:0], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_issue_valid", iv1, 0);
    chk("rst_async_issue_row", ir1, 0);
    chk("rst_async_issue_lane", il1, 0);
    chk("rst_async_done", dn1, 0);
    chk("rst_async_pass_count", pc1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", rr1, 1);
    run(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
